// File: rtl/pea_fifo.sv
// pea_fifo: single-clock circular-buffer FIFO with registered read data and occupancy counts.
//   Parameters: buffer_size (RAM words, power of two, >= 4; capacity buffer_size-1), width (data bits).
//   Ports: clk (rising edge), rst (async active-low), wr_en/rd_en (push/pop requests),
//          data_in (write word), population (stored entries), free_space (buffer_size-1-population),
//          data_out (word from the latest accepted read, held between reads).
//   Optional macro FIFO_ERR_FLAGS_EN adds sticky overflow/underflow outputs, cleared only by reset.

function automatic int pea_fifo_log2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return (r < 1) ? 1 : r;
endfunction

module pea_fifo #(
    parameter int buffer_size = 1024,
    parameter int width = 16,
    localparam int AW = pea_fifo_log2(buffer_size)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic             rd_en,
    input  logic [width-1:0] data_in,
    output logic [AW-1:0]    population,
    output logic [AW-1:0]    free_space,
    output logic [width-1:0] data_out
`ifdef FIFO_ERR_FLAGS_EN
    ,
    output logic             overflow,
    output logic             underflow
`endif
);
    localparam logic [AW-1:0] CAP = AW'(buffer_size - 1);

    logic [width-1:0] FIFO_RAM [0:buffer_size-1];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW-1:0]    r_pop;
    logic [width-1:0] r_data_out;
    logic             w_full;
    logic             w_empty;
    logic             w_wr;
    logic             w_rd;

    assign w_full     = r_pop == CAP;
    assign w_empty    = r_pop == '0;
    assign w_wr       = wr_en && !w_full;
    assign w_rd       = rd_en && !w_empty;
    assign population = r_pop;
    assign free_space = CAP - r_pop;
    assign data_out   = r_data_out;

    // RAM contents survive reset; zeroed pointers and population make stale words unreachable.
    always_ff @(posedge clk) begin
        if (w_wr) FIFO_RAM[r_wr_ptr] <= data_in;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_pop      <= '0;
            r_data_out <= '0;
        end else begin
            if (w_wr) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_rd) begin
                r_rd_ptr   <= r_rd_ptr + AW'(1);
                r_data_out <= FIFO_RAM[r_rd_ptr];
            end
            if (w_wr != w_rd) r_pop <= w_wr ? r_pop + AW'(1) : r_pop - AW'(1);
        end
    end

`ifdef FIFO_ERR_FLAGS_EN
    logic r_overflow;
    logic r_underflow;
    assign overflow  = r_overflow;
    assign underflow = r_underflow;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (wr_en && w_full) r_overflow <= 1'b1;
            if (rd_en && w_empty) r_underflow <= 1'b1;
        end
    end
`endif
endmodule

// File: tb/tb_pea_fifo.sv
// tb_pea_fifo: directed checks of pea_fifo at depth 1024 and depth 8 sharing one stimulus bus.
module tb_pea_fifo;
    logic        clk;
    logic        rst;
    logic        wr_en;
    logic        rd_en;
    logic [15:0] data_in;
    logic [9:0]  big_pop;
    logic [9:0]  big_free;
    logic [15:0] big_dout;
    logic [2:0]  sm_pop;
    logic [2:0]  sm_free;
    logic [15:0] sm_dout;
    int          n_tests;
    int          n_fail;
`ifdef FIFO_ERR_FLAGS_EN
    logic        big_ovf;
    logic        big_unf;
    logic        sm_ovf;
    logic        sm_unf;
`endif

    pea_fifo #(.buffer_size(1024), .width(16)) u_big (
        .clk(clk), .rst(rst), .wr_en(wr_en), .rd_en(rd_en), .data_in(data_in),
        .population(big_pop), .free_space(big_free), .data_out(big_dout)
`ifdef FIFO_ERR_FLAGS_EN
        , .overflow(big_ovf), .underflow(big_unf)
`endif
    );

    pea_fifo #(.buffer_size(8), .width(16)) u_small (
        .clk(clk), .rst(rst), .wr_en(wr_en), .rd_en(rd_en), .data_in(data_in),
        .population(sm_pop), .free_space(sm_free), .data_out(sm_dout)
`ifdef FIFO_ERR_FLAGS_EN
        , .overflow(sm_ovf), .underflow(sm_unf)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One clock with the given request; outputs are stable 1 time unit after the edge.
    task automatic cyc(input logic w, input logic r, input logic [15:0] d);
        wr_en = w;
        rd_en = r;
        data_in = d;
        @(posedge clk);
        #1;
        wr_en = 1'b0;
        rd_en = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        #1;
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    initial begin
        logic [15:0] vec [4];
        vec = '{16'h1234, 16'h0005, 16'h00FF, 16'hA5A5};
        n_tests = 0;
        n_fail = 0;
        rst = 1'b0;
        wr_en = 1'b0;
        rd_en = 1'b0;
        data_in = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;

        // Make state non-trivial, then assert reset mid-cycle and check without an edge.
        cyc(1'b1, 1'b0, 16'hBEEF);
        cyc(1'b0, 1'b1, 16'h0);
        chk("pre_reset_dout", big_dout, 16'hBEEF);
        cyc(1'b1, 1'b0, 16'h7777);
        #2;
        rst = 1'b0;
        #1;
        chk("rst_pop", big_pop, 0);
        chk("rst_free", big_free, 1023);
        chk("rst_dout", big_dout, 0);
        @(posedge clk);
        #1;
        rst = 1'b1;

        for (int i = 0; i < 4; i++) cyc(1'b1, 1'b0, vec[i]);
        chk("big_pop4", big_pop, 4);
        chk("big_free4", big_free, 1019);
        for (int i = 0; i < 4; i++) chk($sformatf("big_ram%0d", i), u_big.FIFO_RAM[i], vec[i]);
        for (int i = 0; i < 4; i++) begin
            rd_en = 1'b1;
            #1;
            chk($sformatf("big_dout_pre%0d", i), big_dout, i == 0 ? 16'h0 : vec[i-1]);
            @(posedge clk);
            #1;
            rd_en = 1'b0;
            chk($sformatf("big_rd%0d", i), big_dout, vec[i]);
        end
        chk("big_pop0", big_pop, 0);
        chk("big_free_end", big_free, 1023);

        // Depth-8 FIFO: full boundary.
        do_reset();
        chk("sm_rst_free", sm_free, 7);
`ifdef FIFO_ERR_FLAGS_EN
        chk("sm_rst_ovf", sm_ovf, 0);
        chk("sm_rst_unf", sm_unf, 0);
`endif
        for (int i = 1; i <= 8; i++) cyc(1'b1, 1'b0, 16'(i));
        chk("full_pop", sm_pop, 7);
        chk("full_free", sm_free, 0);
`ifdef FIFO_ERR_FLAGS_EN
        chk("full_ovf", sm_ovf, 1);
        chk("full_unf", sm_unf, 0);
`endif
        for (int i = 1; i <= 7; i++) begin
            cyc(1'b0, 1'b1, 16'h0);
            chk($sformatf("full_rd%0d", i), sm_dout, 16'(i));
        end
        chk("drain_pop", sm_pop, 0);

        // Empty read leaves data_out alone.
        cyc(1'b0, 1'b1, 16'h0);
        chk("empty_dout", sm_dout, 7);
        chk("empty_pop", sm_pop, 0);
`ifdef FIFO_ERR_FLAGS_EN
        chk("empty_unf", sm_unf, 1);
`endif

        // Simultaneous read/write at population 3, then at population 0.
        for (int i = 10; i <= 12; i++) cyc(1'b1, 1'b0, 16'(i));
        cyc(1'b1, 1'b1, 16'd13);
        chk("sim3_dout", sm_dout, 10);
        chk("sim3_pop", sm_pop, 3);
        for (int i = 11; i <= 13; i++) begin
            cyc(1'b0, 1'b1, 16'h0);
            chk($sformatf("sim3_rd%0d", i), sm_dout, 16'(i));
        end
        cyc(1'b1, 1'b1, 16'd14);
        chk("sim0_pop", sm_pop, 1);
        chk("sim0_dout", sm_dout, 13);
        cyc(1'b0, 1'b1, 16'h0);
        chk("sim0_rd", sm_dout, 14);

        // Stream 20 words through, population capped at 5, crossing pointer wrap.
        for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0, 16'(100 + i));
        chk("wrap_pop5", sm_pop, 5);
        for (int i = 0; i < 15; i++) begin
            cyc(1'b1, 1'b1, 16'(105 + i));
            chk($sformatf("wrap_rd%0d", i), sm_dout, 16'(100 + i));
            chk($sformatf("wrap_pop%0d", i), sm_pop, 5);
        end
        for (int i = 15; i < 20; i++) begin
            cyc(1'b0, 1'b1, 16'h0);
            chk($sformatf("wrap_rd%0d", i), sm_dout, 16'(100 + i));
        end
        chk("wrap_pop_end", sm_pop, 0);
        chk("wrap_free_end", sm_free, 7);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
